csi2_stat_mon: RTL

Parametrised successor to the CSI-2 receiver statistics accumulator. It monitors the pixel-clock AXI4-Stream video output and N error pulse sources, and tracks the following:
- per-source saturating error counts;
- min/max lines per frame;
- min/max pixels per line;
- total frame count;
- frames-per-window rate measurement (new).

It sits beside the CSI-2 receiver, with outputs feeding the CSR block.

---
 rtl/csi2_stat_pkg.sv | 25 ++
 rtl/csi2_minmax_tracker.sv | 32 +++
 rtl/csi2_stat_mon.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/csi2_stat_pkg.sv
// Shared constants and saturating arithmetic for the CSI-2 statistics monitor.
package csi2_stat_pkg;

  localparam int unsigned ERR_HEADER      = 0;
  localparam int unsigned ERR_CORR_HEADER = 1;
  localparam int unsigned ERR_CRC         = 2;
  localparam int unsigned ERR_SRC_CNT_DEF = 3;
  localparam int unsigned CNT_WIDTH_DEF   = 32;

  // Working width of the shared saturating adder; callers zero-extend into it.
  localparam int unsigned SAT_W = 64;
  typedef logic [SAT_W-1:0] sat_word_t;

  function automatic sat_word_t sat_add(input sat_word_t val,
                                        input sat_word_t inc,
                                        input sat_word_t lim);
    logic [SAT_W:0] sum;
    sum = {1'b0, val} + {1'b0, inc};
    if (sum > {1'b0, lim}) begin
      return lim;
    end
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/csi2_minmax_tracker.sv
// Running minimum/maximum of a sampled value; min starts at all ones, max at zero.
module csi2_minmax_tracker
  import csi2_stat_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 clear_i,
  input  logic                 sample_val_i,
  input  logic [CNT_WIDTH-1:0] sample_i,
  output logic [CNT_WIDTH-1:0] min_o,
  output logic [CNT_WIDTH-1:0] max_o
);

  logic [CNT_WIDTH-1:0] r_min;
  logic [CNT_WIDTH-1:0] r_max;

  always_ff @(posedge clk_i) begin
    if (srst_i || clear_i) begin
      r_min <= '1;
      r_max <= '0;
    end else if (sample_val_i) begin
      if (sample_i < r_min) r_min <= sample_i;
      if (sample_i > r_max) r_max <= sample_i;
    end
  end

  assign min_o = r_min;
  assign max_o = r_max;

endmodule

// File: rtl/csi2_stat_mon.sv
// CSI-2 video stream / error statistics monitor with frame-rate measurement.
// Define CSI2_STAT_SNAPSHOT_EN to add snapshot_i and shadow-registered statistic outputs.
module csi2_stat_mon
  import csi2_stat_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned ERR_SRC_CNT = ERR_SRC_CNT_DEF,
  parameter int unsigned PX_PER_BEAT = 1
) (
  input  logic                                  clk_i,
  input  logic                                  srst_i,
  input  logic                                  clear_stat_i,
  input  logic                                  video_tvalid_i,
  input  logic                                  video_tready_i,
  input  logic                                  video_tlast_i,
  input  logic                                  video_tuser_i,
  input  logic [ERR_SRC_CNT-1:0]                err_i,
  input  logic [CNT_WIDTH-1:0]                  fps_window_i,
`ifdef CSI2_STAT_SNAPSHOT_EN
  input  logic                                  snapshot_i,
`endif
  output logic [ERR_SRC_CNT-1:0][CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0]                  frame_cnt_o,
  output logic [CNT_WIDTH-1:0]                  max_ln_per_frame_o,
  output logic [CNT_WIDTH-1:0]                  min_ln_per_frame_o,
  output logic [CNT_WIDTH-1:0]                  max_px_per_ln_o,
  output logic [CNT_WIDTH-1:0]                  min_px_per_ln_o,
  output logic [CNT_WIDTH-1:0]                  fps_o,
  output logic                                  fps_valid_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] PX_INC  = CNT_WIDTH'(PX_PER_BEAT);

  function automatic logic [CNT_WIDTH-1:0] inc_sat(input logic [CNT_WIDTH-1:0] val,
                                                   input logic [CNT_WIDTH-1:0] inc);
    return CNT_WIDTH'(sat_add(SAT_W'(val), SAT_W'(inc), SAT_W'(CNT_MAX)));
  endfunction

  logic                                  w_clr;
  logic                                  w_beat;
  logic                                  w_sof;
  logic                                  w_px_val;
  logic                                  w_ln_val;
  logic [CNT_WIDTH-1:0]                  w_line_len;
  logic                                  w_fps_on;
  logic                                  w_win_term;
  logic [CNT_WIDTH-1:0]                  w_win_frames_nxt;
  logic [CNT_WIDTH-1:0]                  w_min_ln;
  logic [CNT_WIDTH-1:0]                  w_max_ln;
  logic [CNT_WIDTH-1:0]                  w_min_px;
  logic [CNT_WIDTH-1:0]                  w_max_px;

  logic [CNT_WIDTH-1:0]                  r_px_cnt;
  logic [CNT_WIDTH-1:0]                  r_ln_cnt;
  logic [CNT_WIDTH-1:0]                  r_frame_cnt;
  logic [ERR_SRC_CNT-1:0][CNT_WIDTH-1:0] r_err_cnt;
  logic [CNT_WIDTH-1:0]                  r_win_cnt;
  logic [CNT_WIDTH-1:0]                  r_win_frames;
  logic [CNT_WIDTH-1:0]                  r_fps;
  logic                                  r_fps_valid;

  assign w_clr    = srst_i | clear_stat_i;
  assign w_beat   = video_tvalid_i & video_tready_i;
  assign w_sof    = w_beat & video_tuser_i;
  assign w_px_val = w_beat & video_tlast_i;
  assign w_ln_val = w_sof & (r_ln_cnt != '0);

  // A SOF beat drops any partial line, so a SOF+EOL beat is a one-beat line.
  assign w_line_len = video_tuser_i ? PX_INC : inc_sat(r_px_cnt, PX_INC);

  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_px_cnt    <= '0;
      r_ln_cnt    <= '0;
      r_frame_cnt <= '0;
    end else if (w_beat) begin
      if (video_tlast_i) begin
        r_px_cnt <= '0;
      end else if (video_tuser_i) begin
        r_px_cnt <= PX_INC;
      end else begin
        r_px_cnt <= inc_sat(r_px_cnt, PX_INC);
      end

      if (video_tuser_i) begin
        r_ln_cnt <= video_tlast_i ? ONE : '0;
      end else if (video_tlast_i) begin
        r_ln_cnt <= inc_sat(r_ln_cnt, ONE);
      end

      if (w_ln_val) r_frame_cnt <= inc_sat(r_frame_cnt, ONE);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < ERR_SRC_CNT; k++) begin
      if (w_clr) begin
        r_err_cnt[k] <= '0;
      end else if (err_i[k]) begin
        r_err_cnt[k] <= inc_sat(r_err_cnt[k], ONE);
      end
    end
  end

  csi2_minmax_tracker #(.CNT_WIDTH(CNT_WIDTH)) u_ln_tracker (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .clear_i      (clear_stat_i),
    .sample_val_i (w_ln_val),
    .sample_i     (r_ln_cnt),
    .min_o        (w_min_ln),
    .max_o        (w_max_ln)
  );

  csi2_minmax_tracker #(.CNT_WIDTH(CNT_WIDTH)) u_px_tracker (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .clear_i      (clear_stat_i),
    .sample_val_i (w_px_val),
    .sample_i     (w_line_len),
    .min_o        (w_min_px),
    .max_o        (w_max_px)
  );

  // Terminal test uses >= so a window shortened below the running count ends at once.
  assign w_fps_on         = (fps_window_i != '0);
  assign w_win_term       = w_fps_on && (r_win_cnt >= (fps_window_i - ONE));
  assign w_win_frames_nxt = w_sof ? inc_sat(r_win_frames, ONE) : r_win_frames;

  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_win_cnt    <= '0;
      r_win_frames <= '0;
      r_fps        <= '0;
      r_fps_valid  <= 1'b0;
    end else if (!w_fps_on) begin
      r_win_cnt    <= '0;
      r_win_frames <= '0;
      r_fps_valid  <= 1'b0;
    end else if (w_win_term) begin
      r_win_cnt    <= '0;
      r_win_frames <= '0;
      r_fps        <= w_win_frames_nxt;
      r_fps_valid  <= 1'b1;
    end else begin
      r_win_cnt    <= inc_sat(r_win_cnt, ONE);
      r_win_frames <= w_win_frames_nxt;
      r_fps_valid  <= 1'b0;
    end
  end

  assign fps_o       = r_fps;
  assign fps_valid_o = r_fps_valid;

`ifdef CSI2_STAT_SNAPSHOT_EN
  logic [ERR_SRC_CNT-1:0][CNT_WIDTH-1:0] r_sh_err_cnt;
  logic [CNT_WIDTH-1:0]                  r_sh_frame_cnt;
  logic [CNT_WIDTH-1:0]                  r_sh_max_ln;
  logic [CNT_WIDTH-1:0]                  r_sh_min_ln;
  logic [CNT_WIDTH-1:0]                  r_sh_max_px;
  logic [CNT_WIDTH-1:0]                  r_sh_min_px;

  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_sh_err_cnt   <= '0;
      r_sh_frame_cnt <= '0;
      r_sh_max_ln    <= '0;
      r_sh_min_ln    <= '1;
      r_sh_max_px    <= '0;
      r_sh_min_px    <= '1;
    end else if (snapshot_i) begin
      r_sh_err_cnt   <= r_err_cnt;
      r_sh_frame_cnt <= r_frame_cnt;
      r_sh_max_ln    <= w_max_ln;
      r_sh_min_ln    <= w_min_ln;
      r_sh_max_px    <= w_max_px;
      r_sh_min_px    <= w_min_px;
    end
  end

  assign err_cnt_o          = r_sh_err_cnt;
  assign frame_cnt_o        = r_sh_frame_cnt;
  assign max_ln_per_frame_o = r_sh_max_ln;
  assign min_ln_per_frame_o = r_sh_min_ln;
  assign max_px_per_ln_o    = r_sh_max_px;
  assign min_px_per_ln_o    = r_sh_min_px;
`else
  assign err_cnt_o          = r_err_cnt;
  assign frame_cnt_o        = r_frame_cnt;
  assign max_ln_per_frame_o = w_max_ln;
  assign min_ln_per_frame_o = w_min_ln;
  assign max_px_per_ln_o    = w_max_px;
  assign min_px_per_ln_o    = w_min_px;
`endif

endmodule
